// File: rtl/alsu_seq_if.sv
// Request/result bus for alsu_seq: one request channel and one result channel.
// Both channels use valid/ready: a transfer happens on the rising edge where valid && ready; the sender holds its payload stable while valid is high and ready is low.
interface alsu_seq_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         opcode;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               cin;
  logic               SI;
  logic               sh_left;
  logic               red_op_A;
  logic               red_op_B;
  logic               pass_A;
  logic               pass_B;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out;
  logic               err;

  modport master (
    output in_valid, opcode, A, B, cin, SI, sh_left,
           red_op_A, red_op_B, pass_A, pass_B, out_ready,
    input  in_ready, out_valid, out, err
  );

  modport slave (
    input  in_valid, opcode, A, B, cin, SI, sh_left,
           red_op_A, red_op_B, pass_A, pass_B, out_ready,
    output in_ready, out_valid, out, err
  );
endinterface

// File: rtl/alsu_seq.sv
// Sequential ALSU: IDLE/EXEC/DONE handshake FSM around AND/XOR/ADD/MUL/SHIFT/ROTATE.
// Define ALSU_SEQ_MUL_EN to build the EXEC state and shift-add multiplier; otherwise MUL is invalid.
module alsu_seq #(
  parameter int    WIDTH          = 8,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  alsu_seq_if.slave        bus,
  output logic [LED_W-1:0] leds,
  output logic [1:0]       state_dbg
);
  localparam int OW    = 2 * WIDTH;
  localparam bit PRI_A = (INPUT_PRIORITY == "A");
  localparam bit FA_ON = (FULL_ADDER == "ON");
`ifdef ALSU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
  localparam int CW     = $clog2(WIDTH);
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALSU_SEQ_MUL_EN
    EXEC = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   done_load;
  logic   accept;

  logic [2:0]       cap_op,      nxt_op;
  logic [WIDTH-1:0] cap_a,       nxt_a;
  logic [WIDTH-1:0] cap_b,       nxt_b;
  logic             cap_cin,     nxt_cin;
  logic             cap_si,      nxt_si;
  logic             cap_sh_left, nxt_sh_left;
  logic             cap_red_a,   nxt_red_a;
  logic             cap_red_b,   nxt_red_b;
  logic             cap_pass_a,  nxt_pass_a;
  logic             cap_pass_b,  nxt_pass_b;

  logic [OW-1:0]    out_r;
  logic             err_r;
  logic [LED_W-1:0] leds_r;

  logic             red_any, red_use_a, pass_use_a, pass_use_b, is_mul, invalid;
  logic [WIDTH-1:0] red_opnd, low;
  logic [OW-1:0]    op_result, sel_result, mul_final;

`ifdef ALSU_SEQ_MUL_EN
  logic [OW-1:0]    mul_acc, mul_mcand;
  logic [WIDTH-1:0] mul_mplier;
  logic [CW-1:0]    mul_cnt;

  // One partial product per EXEC cycle; the last one is folded into the result write.
  assign mul_final = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
`else
  assign mul_final = '0;
`endif

  assign accept = bus.in_valid && bus.in_ready;

  // Captured copies: freshly sampled on acceptance, otherwise the held request.
  assign nxt_op      = accept ? bus.opcode   : cap_op;
  assign nxt_a       = accept ? bus.A        : cap_a;
  assign nxt_b       = accept ? bus.B        : cap_b;
  assign nxt_cin     = accept ? bus.cin      : cap_cin;
  assign nxt_si      = accept ? bus.SI       : cap_si;
  assign nxt_sh_left = accept ? bus.sh_left  : cap_sh_left;
  assign nxt_red_a   = accept ? bus.red_op_A : cap_red_a;
  assign nxt_red_b   = accept ? bus.red_op_B : cap_red_b;
  assign nxt_pass_a  = accept ? bus.pass_A   : cap_pass_a;
  assign nxt_pass_b  = accept ? bus.pass_B   : cap_pass_b;

  assign red_any    = nxt_red_a || nxt_red_b;
  assign red_use_a  = nxt_red_a && (!nxt_red_b || PRI_A);
  assign red_opnd   = red_use_a ? nxt_a : nxt_b;
  assign pass_use_a = nxt_pass_a && (!nxt_pass_b || PRI_A);
  assign pass_use_b = nxt_pass_b && !pass_use_a;
  assign is_mul     = (nxt_op == 3'b011);
  assign invalid    = (nxt_op[2:1] == 2'b11)
                   || (red_any && (nxt_op[2:1] != 2'b00))
                   || (is_mul && !MUL_EN);
  assign low        = out_r[WIDTH-1:0];

  always_comb begin
    op_result = '0;
    case (nxt_op)
      3'b000: op_result = red_any ? OW'(&red_opnd) : OW'(nxt_a & nxt_b);
      3'b001: op_result = red_any ? OW'(^red_opnd) : OW'(nxt_a ^ nxt_b);
      3'b010: op_result = OW'(nxt_a) + OW'(nxt_b) + OW'(FA_ON && nxt_cin);
      3'b011: op_result = mul_final;
      3'b100: op_result = OW'(nxt_sh_left ? {low[WIDTH-2:0], nxt_si}
                                          : {nxt_si, low[WIDTH-1:1]});
      3'b101: op_result = OW'(nxt_sh_left ? {low[WIDTH-2:0], low[WIDTH-1]}
                                          : {low[0], low[WIDTH-1:1]});
      default: op_result = '0;
    endcase
  end

  always_comb begin
    sel_result = op_result;
    if (invalid)         sel_result = '0;
    else if (pass_use_a) sel_result = OW'(nxt_a);
    else if (pass_use_b) sel_result = OW'(nxt_b);
  end

  always_comb begin
    state_nxt = state;
    done_load = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (MUL_EN && is_mul && !invalid) begin
`ifdef ALSU_SEQ_MUL_EN
            state_nxt = EXEC;
`endif
          end else begin
            state_nxt = DONE;
            done_load = 1'b1;
          end
        end
      end
`ifdef ALSU_SEQ_MUL_EN
      EXEC: begin
        if (mul_cnt == CW'(WIDTH - 1)) begin
          state_nxt = DONE;
          done_load = 1'b1;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cap_op      <= '0;
      cap_a       <= '0;
      cap_b       <= '0;
      cap_cin     <= 1'b0;
      cap_si      <= 1'b0;
      cap_sh_left <= 1'b0;
      cap_red_a   <= 1'b0;
      cap_red_b   <= 1'b0;
      cap_pass_a  <= 1'b0;
      cap_pass_b  <= 1'b0;
      out_r       <= '0;
      err_r       <= 1'b0;
      leds_r      <= '0;
    end else begin
      state       <= state_nxt;
      cap_op      <= nxt_op;
      cap_a       <= nxt_a;
      cap_b       <= nxt_b;
      cap_cin     <= nxt_cin;
      cap_si      <= nxt_si;
      cap_sh_left <= nxt_sh_left;
      cap_red_a   <= nxt_red_a;
      cap_red_b   <= nxt_red_b;
      cap_pass_a  <= nxt_pass_a;
      cap_pass_b  <= nxt_pass_b;
      if (done_load) begin
        out_r  <= sel_result;
        err_r  <= invalid;
        leds_r <= invalid ? ~leds_r : '0;
      end
    end
  end

`ifdef ALSU_SEQ_MUL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
    end else if (accept) begin
      mul_acc    <= '0;
      mul_mcand  <= OW'(bus.A);
      mul_mplier <= bus.B;
      mul_cnt    <= '0;
    end else if (state == EXEC) begin
      mul_acc    <= mul_final;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + 1'b1;
    end
  end
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_r;
  assign bus.err       = err_r;
  assign leds          = leds_r;
  assign state_dbg     = state;
endmodule

// File: tb/tb_alsu_seq.sv
// Directed bench for alsu_seq (WIDTH=8): default instance plus a FULL_ADDER="OFF" instance
// driven with identical stimulus.
module tb_alsu_seq;
  localparam int W = 8;
  // flag bits for issue(): {cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B}
  localparam logic [6:0] F_CIN = 7'b1000000;
  localparam logic [6:0] F_SI  = 7'b0100000;
  localparam logic [6:0] F_SHL = 7'b0010000;
  localparam logic [6:0] F_RA  = 7'b0001000;
  localparam logic [6:0] F_RB  = 7'b0000100;
  localparam logic [6:0] F_PA  = 7'b0000010;
  localparam logic [6:0] F_PB  = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] leds, leds2;
  logic [1:0]  st, st2;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  alsu_seq_if #(.WIDTH(W)) bus  ();
  alsu_seq_if #(.WIDTH(W)) bus2 ();

  alsu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .leds(leds), .state_dbg(st)
  );
  alsu_seq #(.WIDTH(W), .FULL_ADDER("OFF")) dut_off (
    .clk(clk), .rst(rst), .bus(bus2), .leds(leds2), .state_dbg(st2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [6:0] f);
    bus.opcode  = op;  bus2.opcode  = op;
    bus.A       = a;   bus2.A       = a;
    bus.B       = b;   bus2.B       = b;
    bus.cin      = f[6]; bus2.cin      = f[6];
    bus.SI       = f[5]; bus2.SI       = f[5];
    bus.sh_left  = f[4]; bus2.sh_left  = f[4];
    bus.red_op_A = f[3]; bus2.red_op_A = f[3];
    bus.red_op_B = f[2]; bus2.red_op_B = f[2];
    bus.pass_A   = f[1]; bus2.pass_A   = f[1];
    bus.pass_B   = f[0]; bus2.pass_B   = f[0];
  endtask

  // Presents a request for one edge; returns at cycle 1 after acceptance.
  task automatic issue(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [6:0] f);
    req(op, a, b, f);
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus2.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic consume();
    bus.out_ready = 1'b1; bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus2.out_ready = 1'b0;
  endtask

  task automatic simple_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [6:0] f,
                           input logic [15:0] exp_out, input logic exp_err);
    issue(tag, op, a, b, f);
    wait_valid(tag, 1);
    check({tag, " out"}, 32'(bus.out), 32'(exp_out));
    check({tag, " err"}, 32'(bus.err), 32'(exp_err));
  endtask

  initial begin
    bus.in_valid = 1'b0; bus2.in_valid = 1'b0;
    bus.out_ready = 1'b0; bus2.out_ready = 1'b0;
    req(3'b000, 8'h00, 8'h00, 7'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out", 32'(bus.out), 32'd0);
    check("rst err", 32'(bus.err), 32'd0);
    check("rst leds", 32'(leds), 32'd0);
    check("rst state", 32'(st), 32'd0);

    // AND, then hold the result with out_ready low while a new request is offered
    simple_op("and", 3'b000, 8'hF0, 8'h3C, 7'b0, 16'h0030, 1'b0);
    req(3'b001, 8'h55, 8'hAA, 7'b0);
    bus.in_valid = 1'b1; bus2.in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("hold out", 32'(bus.out), 32'h0030);
    check("hold in_ready", 32'(bus.in_ready), 32'd0);
    check("hold out_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0; bus2.in_valid = 1'b0;
    consume();
    check("after consume in_ready", 32'(bus.in_ready), 32'd1);

    issue("add", 3'b010, 8'hFF, 8'h01, F_CIN);
    wait_valid("add", 1);
    check("add out", 32'(bus.out), 32'h0101);
    check("add_nocin out", 32'(bus2.out), 32'h0100);
    consume();

    simple_op("and red both", 3'b000, 8'hFF, 8'h0F, F_RA | F_RB, 16'h0001, 1'b0); consume();
    simple_op("xor red b", 3'b001, 8'h07, 8'h03, F_RB, 16'h0000, 1'b0); consume();
    simple_op("pass both", 3'b010, 8'h12, 8'h34, F_PA | F_PB, 16'h0012, 1'b0); consume();
    simple_op("pass b", 3'b000, 8'h12, 8'h34, F_PB, 16'h0034, 1'b0); consume();

`ifdef ALSU_SEQ_MUL_EN
    issue("mul", 3'b011, 8'hFF, 8'hFF, 7'b0);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("mul exec%0d in_ready", i), 32'(bus.in_ready), 32'd0);
      check($sformatf("mul exec%0d out_valid", i), 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("mul out_valid", 32'(bus.out_valid), 32'd1);
    check("mul out", 32'(bus.out), 32'hFE01);
    check("mul err", 32'(bus.err), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("mul hold%0d out", i), 32'(bus.out), 32'hFE01);
      check($sformatf("mul hold%0d valid", i), 32'(bus.out_valid), 32'd1);
    end
    consume();
`else
    simple_op("mul off", 3'b011, 8'hFF, 8'hFF, 7'b0, 16'h0000, 1'b1);
    check("mul off leds", 32'(leds), 32'hFFFF);
    consume();
`endif
    simple_op("xor", 3'b001, 8'h0F, 8'hF0, 7'b0, 16'h00FF, 1'b0);
    check("xor leds", 32'(leds), 32'h0000);
    consume();

    simple_op("inv1", 3'b110, 8'h12, 8'h34, 7'b0, 16'h0000, 1'b1);
    check("inv1 leds", 32'(leds), 32'hFFFF); consume();
    simple_op("inv2", 3'b110, 8'h12, 8'h34, 7'b0, 16'h0000, 1'b1);
    check("inv2 leds", 32'(leds), 32'h0000); consume();
    simple_op("inv red add", 3'b010, 8'h12, 8'h34, F_RA, 16'h0000, 1'b1);
    check("inv red leds", 32'(leds), 32'hFFFF); consume();
    simple_op("and 81", 3'b000, 8'h81, 8'hFF, 7'b0, 16'h0081, 1'b0);
    check("and 81 leds", 32'(leds), 32'h0000); consume();

    simple_op("rotl", 3'b101, 8'h00, 8'h00, F_SHL, 16'h0003, 1'b0); consume();
    simple_op("shr si1", 3'b100, 8'h00, 8'h00, F_SI, 16'h0081, 1'b0); consume();
    simple_op("shl si0", 3'b100, 8'h00, 8'h00, F_SHL, 16'h0002, 1'b0); consume();
    simple_op("rotr", 3'b101, 8'h00, 8'h00, 7'b0, 16'h0001, 1'b0); consume();

    simple_op("inv pre rst", 3'b111, 8'h00, 8'h00, 7'b0, 16'h0000, 1'b1);
    check("inv pre rst leds", 32'(leds), 32'hFFFF);
`ifdef ALSU_SEQ_MUL_EN
    consume();
    issue("mul abort", 3'b011, 8'hFF, 8'hFF, 7'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("mul abort in exec", 32'(st), 32'd1);
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2 in_ready", 32'(bus.in_ready), 32'd1);
    check("rst2 out_valid", 32'(bus.out_valid), 32'd0);
    check("rst2 out", 32'(bus.out), 32'd0);
    check("rst2 leds", 32'(leds), 32'd0);
    check("rst2 err", 32'(bus.err), 32'd0);

    simple_op("and post rst", 3'b000, 8'hAA, 8'h0F, 7'b0, 16'h000A, 1'b0);
    consume();
    check("final idle", 32'(bus.in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
